// File: rtl/output_buffer_fifo_if.sv
// Signal bundle for output_buffer_fifo: en/data write side, valid/ready read side and status.
// almost_full is part of the bundle only when OUTBUF_AF_EN is defined.
interface output_buffer_fifo_if #(
    parameter int DATA_W = 8,
    parameter int SLOTS  = 5
);
    localparam int CW = $clog2(SLOTS + 1);

    logic              en;
    logic [DATA_W-1:0] data;
    logic              data_stored;
    logic              full;
    logic              empty;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              clr_ovf;

`ifdef OUTBUF_AF_EN
    logic              almost_full;

    modport master (
        output en, data, rd_ready, clr_ovf,
        input  data_stored, full, empty, rd_valid, rd_data, count, overflow, almost_full
    );

    modport slave (
        input  en, data, rd_ready, clr_ovf,
        output data_stored, full, empty, rd_valid, rd_data, count, overflow, almost_full
    );
`else
    modport master (
        output en, data, rd_ready, clr_ovf,
        input  data_stored, full, empty, rd_valid, rd_data, count, overflow
    );

    modport slave (
        input  en, data, rd_ready, clr_ovf,
        output data_stored, full, empty, rd_valid, rd_data, count, overflow
    );
`endif
endinterface

// File: rtl/output_buffer_fifo.sv
// Router output-port FIFO: SLOTS-entry circular store, show-ahead valid/ready read side,
// occupancy count and sticky overflow. Define OUTBUF_AF_EN to add a registered almost_full.
module output_buffer_fifo #(
    parameter int DATA_W   = 8,
    parameter int SLOTS    = 5
`ifdef OUTBUF_AF_EN
    ,
    parameter int AF_LEVEL = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    output_buffer_fifo_if.slave  bus
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam int PW = $clog2(SLOTS);
    localparam logic [PW-1:0] PTR_LAST = PW'(SLOTS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SLOTS);

    logic [DATA_W-1:0] mem_q [SLOTS];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              data_stored_q, data_stored_d;
    logic              overflow_q, overflow_d;
    logic              full_s, empty_s;
    logic              wr_acc_s, rd_acc_s, drop_s;
    logic [DATA_W-1:0] rd_data_s;

    // SLOTS need not be a power of two, so wrap by compare rather than by overflow
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1'b1);
        end
    endfunction

    // Handshake decode and next-state for pointers, count and flags
    always_comb begin
        full_s        = (count_q == CNT_FULL);
        empty_s       = (count_q == {CW{1'b0}});
        rd_acc_s      = !empty_s && bus.rd_ready;
        wr_acc_s      = bus.en && (!full_s || rd_acc_s);
        drop_s        = bus.en && !wr_acc_s;
        data_stored_d = wr_acc_s;

        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear must still be reported
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Show-ahead head entry, forced to zero while nothing is held
    always_comb begin
        if (!empty_s) begin
            rd_data_s = mem_q[rd_ptr_q];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            data_stored_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_stored_q <= data_stored_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage array; popped entries keep their contents until overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.data_stored = data_stored_q;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.rd_valid    = !empty_s;
    assign bus.rd_data     = rd_data_s;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;

`ifdef OUTBUF_AF_EN
    logic almost_full_q;

    // Threshold taken from the next-state count so it moves in the same edge as count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= CW'(AF_LEVEL));
        end
    end

    assign bus.almost_full = almost_full_q;
`endif

endmodule
